ifetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle RV core. Holds the program counter, drives the byte address into the 64-byte instruction memory, and captures the returned little-endian word. It presents the word to decode through a valid/ready output register. It also handles control-flow redirects, back-pressure, and out-of-range or misaligned fetch faults.

---
 rtl/ifetch_unit_if.sv | 46 ++++
 rtl/ifetch_unit.sv | 92 +++++++++
 tb/tb_ifetch_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bundle: instruction memory port, redirect input, decode output, status.
// Latency: none (signal grouping only).
// Backpressure: OutValid/OutReady handshake toward decode.
interface ifetch_unit_if;
   logic [31:0] ImemAddr;
   logic [31:0] ImemData;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] OutInstr;
   logic [31:0] OutPC;
   logic        Fault;
   logic [31:0] FaultPC;
   logic [31:0] FetchCount;

   // Fetch unit side
   modport master (
      output ImemAddr,
      input  ImemData,
      input  Redirect,
      input  RedirectPC,
      output OutValid,
      input  OutReady,
      output OutInstr,
      output OutPC,
      output Fault,
      output FaultPC,
      output FetchCount
   );

   // Environment side (memory, branch unit, decode)
   modport slave (
      input  ImemAddr,
      output ImemData,
      output Redirect,
      output RedirectPC,
      input  OutValid,
      output OutReady,
      input  OutInstr,
      input  OutPC,
      input  Fault,
      input  FaultPC,
      input  FetchCount
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC register, IMEM addressing, valid/ready output register, fault halt.
// Latency: word at PC appears on OutInstr one cycle after PC is driven on ImemAddr.
// Backpressure: OutValid & !OutReady holds PC and the output register stable.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_BYTES = 64
) (
   input  logic          Clk,
   input  logic          Rst,
   ifetch_unit_if.master bus
);

   localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

   typedef enum logic {RUN, HALT} state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic        out_valid_q;
   logic [31:0] out_instr_q;
   logic [31:0] out_pc_q;
   logic        fault_q;
   logic [31:0] fault_pc_q;
   logic [31:0] count_q;

   logic [31:0] count_d;
   logic [31:0] pc_inc_d;
   logic        reg_free;
   logic        pc_legal;
   logic        redir_legal;

   // Decision terms for the next edge: free slot, PC/target legality, handshake count
   always_comb begin
      reg_free    = !out_valid_q || bus.OutReady;
      pc_legal    = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);
      redir_legal = (bus.RedirectPC[1:0] == 2'b00) && (bus.RedirectPC <= LAST_PC);
      pc_inc_d    = pc_q + 32'd4;
      count_d     = count_q;
      if (out_valid_q && bus.OutReady) begin
         count_d = count_q + 32'd1;
      end
   end

   // RUN/HALT state machine owning PC, the output register and the fault record
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q     <= RUN;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_instr_q <= 32'h0;
         out_pc_q    <= 32'h0;
         fault_q     <= 1'b0;
         fault_pc_q  <= 32'h0;
         count_q     <= 32'h0;
      end else begin
         // A word taken on this edge counts even if it is flushed or HALT is entered
         count_q <= count_d;
         if (state_q == RUN) begin
            if (bus.Redirect) begin
               out_valid_q <= 1'b0;
               if (redir_legal) begin
                  pc_q <= bus.RedirectPC;
               end else begin
                  state_q    <= HALT;
                  fault_q    <= 1'b1;
                  fault_pc_q <= bus.RedirectPC;
               end
            end else if (reg_free && pc_legal) begin
               out_instr_q <= bus.ImemData;
               out_pc_q    <= pc_q;
               out_valid_q <= 1'b1;
               pc_q        <= pc_inc_d;
            end else if (reg_free) begin
               // Sequential fetch ran past the end of instruction memory
               state_q     <= HALT;
               fault_q     <= 1'b1;
               fault_pc_q  <= pc_q;
               out_valid_q <= 1'b0;
            end
         end
      end
   end

   assign bus.ImemAddr   = pc_q;
   assign bus.OutValid   = out_valid_q;
   assign bus.OutInstr   = out_instr_q;
   assign bus.OutPC      = out_pc_q;
   assign bus.Fault      = fault_q;
   assign bus.FaultPC    = fault_pc_q;
   assign bus.FetchCount = count_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized traffic against a reference model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: OutReady driven directly and randomized.
module tb_ifetch_unit;

   logic Clk = 1'b0;
   logic Rst;
   ifetch_unit_if bus();

   ifetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(64)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus.master)
   );

   always #5 Clk = ~Clk;

   logic [31:0] mem [16];

   // Instruction memory: 16 words, returns a marker pattern outside the array
   always_comb begin
      bus.ImemData = 32'hDEAD_BEEF;
      if (bus.ImemAddr < 32'd64) bus.ImemData = mem[bus.ImemAddr[5:2]];
   end

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: what each output should show after the edge
   logic [31:0] m_pc, m_instr, m_opc, m_fpc, m_cnt;
   bit          m_valid, m_halt, m_fault;

   function automatic bit legal(input logic [31:0] a);
      return (a % 4 == 0) && (a <= 32'd60);
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a < 32'd64) return mem[int'(a) / 4];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic model_edge(input logic rst, input logic redir,
                             input logic [31:0] rpc, input logic rdy);
      if (!rst) begin
         m_pc = 32'h0; m_valid = 0; m_instr = 0; m_opc = 0;
         m_halt = 0; m_fault = 0; m_fpc = 0; m_cnt = 0;
      end else begin
         if (m_valid && rdy) m_cnt = m_cnt + 1;
         if (!m_halt) begin
            if (redir) begin
               m_valid = 0;
               if (legal(rpc)) m_pc = rpc;
               else begin m_halt = 1; m_fault = 1; m_fpc = rpc; end
            end else if (!m_valid || rdy) begin
               if (legal(m_pc)) begin
                  m_instr = word_at(m_pc); m_opc = m_pc; m_valid = 1; m_pc = m_pc + 4;
               end else begin
                  m_halt = 1; m_fault = 1; m_fpc = m_pc; m_valid = 0;
               end
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".ImemAddr"},   bus.ImemAddr,   m_pc);
      chk({tag, ".OutValid"},   {31'b0, bus.OutValid}, {31'b0, m_valid});
      chk({tag, ".Fault"},      {31'b0, bus.Fault},    {31'b0, m_fault});
      chk({tag, ".FaultPC"},    bus.FaultPC,    m_fpc);
      chk({tag, ".FetchCount"}, bus.FetchCount, m_cnt);
      if (m_valid || !Rst) begin
         chk({tag, ".OutInstr"}, bus.OutInstr, m_instr);
         chk({tag, ".OutPC"},    bus.OutPC,    m_opc);
      end
   endtask

   task automatic step(input string tag, input logic rst, input logic redir,
                       input logic [31:0] rpc, input logic rdy);
      Rst            = rst;
      bus.Redirect   = redir;
      bus.RedirectPC = rpc;
      bus.OutReady   = rdy;
      model_edge(rst, redir, rpc, rdy);
      @(posedge Clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      mem[0] = 32'h0000_0013;
      mem[1] = 32'h0010_0093;

      // Reset state
      step("rst0", 1'b0, 1'b0, 32'h0, 1'b1);
      step("rst1", 1'b0, 1'b0, 32'h0, 1'b1);
      chk("rst_valid", {31'b0, bus.OutValid}, 32'h0);
      chk("rst_count", bus.FetchCount, 32'h0);
      chk("rst_addr",  bus.ImemAddr, 32'h0);

      // Sequential fetch
      step("seq1", 1'b1, 1'b0, 32'h0, 1'b1);
      chk("seq1_pc",    bus.OutPC, 32'h0);
      chk("seq1_instr", bus.OutInstr, 32'h0000_0013);
      step("seq2", 1'b1, 1'b0, 32'h0, 1'b1);
      chk("seq2_pc",    bus.OutPC, 32'h4);
      chk("seq2_instr", bus.OutInstr, 32'h0010_0093);
      chk("seq2_count", bus.FetchCount, 32'd1);
      step("seq3", 1'b1, 1'b0, 32'h0, 1'b1);
      chk("seq3_pc", bus.OutPC, 32'h8);

      // Back-pressure while OutPC=8
      for (int i = 0; i < 3; i++) begin
         step("stall", 1'b1, 1'b0, 32'h0, 1'b0);
         chk("stall_pc",   bus.OutPC, 32'h8);
         chk("stall_addr", bus.ImemAddr, 32'hC);
         chk("stall_cnt",  bus.FetchCount, 32'd2);
      end
      step("release", 1'b1, 1'b0, 32'h0, 1'b1);
      chk("release_pc",  bus.OutPC, 32'hC);
      chk("release_cnt", bus.FetchCount, 32'd3);

      // Redirect while a word is being accepted
      step("redir", 1'b1, 1'b1, 32'h20, 1'b1);
      chk("redir_cnt",   bus.FetchCount, 32'd4);
      chk("redir_valid", {31'b0, bus.OutValid}, 32'h0);
      chk("redir_addr",  bus.ImemAddr, 32'h20);
      step("redir_tgt", 1'b1, 1'b0, 32'h0, 1'b1);
      chk("redir_tgt_pc", bus.OutPC, 32'h20);

      // Misaligned redirect halts; later redirects ignored
      step("misal", 1'b1, 1'b1, 32'h22, 1'b1);
      chk("misal_fault", {31'b0, bus.Fault}, 32'h1);
      chk("misal_fpc",   bus.FaultPC, 32'h22);
      step("halt_redir", 1'b1, 1'b1, 32'h0, 1'b1);
      step("halt_idle",  1'b1, 1'b0, 32'h0, 1'b0);
      chk("halt_addr", bus.ImemAddr, 32'h24);

      // Reset during a stall in HALT, then resume
      step("halt_rst", 1'b0, 1'b0, 32'h0, 1'b0);
      chk("halt_rst_fault", {31'b0, bus.Fault}, 32'h0);
      step("resume", 1'b1, 1'b0, 32'h0, 1'b1);
      chk("resume_valid", {31'b0, bus.OutValid}, 32'h1);
      chk("resume_pc",    bus.OutPC, 32'h0);

      // Run off the end of memory
      for (int i = 0; i < 15; i++) step("run", 1'b1, 1'b0, 32'h0, 1'b1);
      chk("end_pc", bus.OutPC, 32'h3C);
      chk("end_instr", bus.OutInstr, mem[15]);
      step("off_end", 1'b1, 1'b0, 32'h0, 1'b1);
      chk("off_fault", {31'b0, bus.Fault}, 32'h1);
      chk("off_fpc",   bus.FaultPC, 32'h40);
      chk("off_cnt",   bus.FetchCount, 32'd16);

      // Randomized traffic against the model
      step("rnd_rst", 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         int unsigned r;
         logic [31:0] tgt;
         r   = $urandom_range(0, 99);
         tgt = ($urandom_range(0, 9) < 8) ? {26'b0, 4'($urandom_range(0, 15)), 2'b00}
                                          : 32'($urandom);
         step("rnd", (r >= 3), (r >= 3 && r < 10), tgt, ($urandom_range(0, 3) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
